m_lsu: RTL and testbench

- Parametrised memory-stage load/store unit, successor to the combinational M-stage load extender.
- Accepts one memory instruction at a time from the M stage and checks its alignment and legality.
- Issues a word/doubleword request with byte enables on a variable-latency req/ack data bus, then returns the extended load result or an exception.
- Stalls the pipeline while a transaction is outstanding and raises a bus-timeout exception if the bus never acknowledges.

---
 rtl/m_lsu.sv | 199 +++++++++++++++++++
 tb/tb_m_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_lsu.sv
// Memory-stage load/store unit: checks alignment and legality, runs one req/ack bus
// transaction at a time, and returns the extended load data or an exception code.
module m_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [3:0]          i_op,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_exc,
    output logic [2:0]          o_exc_code,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    localparam int BEW  = DATA_W / 8;
    localparam int OFFW = $clog2(BEW);
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_NONE = 4'd0,  OP_LW = 4'd1,  OP_LH = 4'd2,  OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4,  OP_LBU = 4'd5, OP_SW = 4'd6,  OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8,  OP_LD = 4'd9,  OP_LWU = 4'd10, OP_SD = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              r_state, w_next;
    logic                r_done, r_exc, r_kill, r_mem_req, r_mem_we;
    logic [2:0]          r_exc_code;
    logic [DATA_W-1:0]   r_rdata, r_mem_wdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [BEW-1:0]      r_mem_be;
    logic [3:0]          r_op;
    logic [OFFW-1:0]     r_off;
    logic [CW-1:0]       r_cnt;

    logic [3:0]          w_size;
    logic                w_store, w_illegal, w_misal, w_accept, w_tmo, w_stall;
    logic [2:0]          w_code;

    function automatic logic [3:0] f_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:  f_size = 4'd1;
            OP_LH, OP_LHU, OP_SH:  f_size = 4'd2;
            OP_LW, OP_LWU, OP_SW:  f_size = 4'd4;
            OP_LD, OP_SD:          f_size = 4'd8;
            default:               f_size = 4'd0;
        endcase
    endfunction

    function automatic logic [BEW-1:0] f_be(input logic [3:0] size, input logic [OFFW-1:0] off);
        logic [BEW-1:0] m;
        case (size)
            4'd1:    m = BEW'(1);
            4'd2:    m = BEW'(3);
            4'd4:    m = BEW'(15);
            default: m = '1;
        endcase
        return m << off;
    endfunction

    function automatic logic [DATA_W-1:0] f_rep(input logic [3:0] size, input logic [DATA_W-1:0] wd);
        case (size)
            4'd1:    f_rep = {BEW{wd[7:0]}};
            4'd2:    f_rep = {(DATA_W/16){wd[15:0]}};
            4'd4:    f_rep = {(DATA_W/32){wd[31:0]}};
            default: f_rep = wd;
        endcase
    endfunction

    // Select the addressed lane, then sign- or zero-extend it to the register width.
    function automatic logic [DATA_W-1:0] f_extend(input logic [3:0] op, input logic [OFFW-1:0] off,
                                                   input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] sh;
        sh = d >> {off, 3'b000};
        case (op)
            OP_LB:   f_extend = DATA_W'($signed(sh[7:0]));
            OP_LBU:  f_extend = DATA_W'(sh[7:0]);
            OP_LH:   f_extend = DATA_W'($signed(sh[15:0]));
            OP_LHU:  f_extend = DATA_W'(sh[15:0]);
            OP_LW:   f_extend = DATA_W'($signed(sh[31:0]));
            OP_LWU:  f_extend = DATA_W'(sh[31:0]);
            OP_LD:   f_extend = sh;
            default: f_extend = '0;
        endcase
    endfunction

    assign w_size    = f_size(i_op);
    assign w_store   = (i_op == OP_SW) | (i_op == OP_SH) | (i_op == OP_SB) | (i_op == OP_SD);
    assign w_illegal = (i_op >= 4'd12) | ((DATA_W == 32) && (i_op >= OP_LD));
    assign w_misal   = |(i_addr[2:0] & (w_size[2:0] - 3'd1));
    assign w_code    = w_illegal ? 3'd3 : (w_misal ? (w_store ? 3'd2 : 3'd1) : 3'd0);
    assign w_accept  = (r_state == S_IDLE) & i_valid & (i_op != OP_NONE) & ~i_flush;
    assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = i_valid & (i_op != OP_NONE);
                if (w_accept) w_next = (w_code != 3'd0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (i_mem_ack | w_tmo) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_done      <= 1'b0;
            r_exc       <= 1'b0;
            r_exc_code  <= 3'd0;
            r_rdata     <= '0;
            r_kill      <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_op        <= OP_NONE;
            r_off       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_code <= 3'd0;
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    r_cnt  <= '0;
                    if (w_accept && w_code != 3'd0) begin
                        r_done     <= 1'b1;
                        r_exc      <= 1'b1;
                        r_exc_code <= w_code;
                        r_rdata    <= '0;
                    end else if (w_accept) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_store;
                        r_mem_addr  <= {i_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                        r_mem_be    <= f_be(w_size, i_addr[OFFW-1:0]);
                        r_mem_wdata <= f_rep(w_size, i_wdata);
                        r_op        <= i_op;
                        r_off       <= i_addr[OFFW-1:0];
                    end
                end
                S_REQ: begin
                    // A flush never aborts the bus cycle; it only suppresses the result pulse.
                    if (i_flush) r_kill <= 1'b1;
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= f_extend(r_op, r_off, i_mem_rdata);
                        r_done    <= ~(r_kill | i_flush);
                    end else if (w_tmo) begin
                        r_mem_req  <= 1'b0;
                        r_rdata    <= '0;
                        r_done     <= ~(r_kill | i_flush);
                        r_exc      <= ~(r_kill | i_flush);
                        r_exc_code <= (r_kill | i_flush) ? 3'd0 : 3'd4;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_kill <= 1'b0;
            endcase
        end
    end

    assign o_stall     = w_stall;
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_exc       = r_exc;
    assign o_exc_code  = r_exc_code;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_m_lsu.sv
// Directed bench for m_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_m_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          n_chk  = 0;
    int          n_pass = 0;

    logic        a_valid, a_flush, a_ack, a_stall, a_done, a_exc, a_req, a_we;
    logic [3:0]  a_op, a_be;
    logic [2:0]  a_code;
    logic [31:0] a_addr, a_wdata, a_mrdata, a_rdata, a_maddr, a_mwdata;

    logic        b_valid, b_flush, b_ack, b_stall, b_done, b_exc, b_req, b_we;
    logic [3:0]  b_op;
    logic [7:0]  b_be;
    logic [2:0]  b_code;
    logic [31:0] b_addr, b_maddr;
    logic [63:0] b_wdata, b_mrdata, b_rdata, b_mwdata;

    m_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
        .i_clk(clk), .i_reset(rst), .i_valid(a_valid), .i_op(a_op), .i_addr(a_addr),
        .i_wdata(a_wdata), .i_flush(a_flush), .o_stall(a_stall), .o_done(a_done),
        .o_rdata(a_rdata), .o_exc(a_exc), .o_exc_code(a_code), .o_mem_req(a_req),
        .o_mem_we(a_we), .o_mem_addr(a_maddr), .o_mem_be(a_be), .o_mem_wdata(a_mwdata),
        .i_mem_ack(a_ack), .i_mem_rdata(a_mrdata));

    m_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
        .i_clk(clk), .i_reset(rst), .i_valid(b_valid), .i_op(b_op), .i_addr(b_addr),
        .i_wdata(b_wdata), .i_flush(b_flush), .o_stall(b_stall), .o_done(b_done),
        .o_rdata(b_rdata), .o_exc(b_exc), .o_exc_code(b_code), .o_mem_req(b_req),
        .o_mem_we(b_we), .o_mem_addr(b_maddr), .o_mem_be(b_be), .o_mem_wdata(b_mwdata),
        .i_mem_ack(b_ack), .i_mem_rdata(b_mrdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        a_valid = 0; a_flush = 0; a_ack = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_mrdata = 0;
        b_valid = 0; b_flush = 0; b_ack = 0; b_op = 0; b_addr = 0; b_wdata = 0; b_mrdata = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_done", a_done, 0);
        chk("rst_req", a_req, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_be", a_be, 0);
        chk("rst_addr", a_maddr, 0);
        chk("rst_exc", a_exc, 0);
        chk("rst_stall", a_stall, 0);

        // LB at 0x1003, ack two cycles after the request appears
        a_valid = 1; a_op = 4; a_addr = 32'h1003;
        #1 chk("lb_stall_idle", a_stall, 1);
        tick();
        a_valid = 0; a_op = 0;
        chk("lb_req", a_req, 1);
        chk("lb_be", a_be, 4'b1000);
        chk("lb_addr", a_maddr, 32'h1000);
        chk("lb_we", a_we, 0);
        chk("lb_stall_req", a_stall, 1);
        tick();
        chk("lb_req_hold", a_req, 1);
        tick();
        a_ack = 1; a_mrdata = 32'h80FF_1234;
        tick();
        a_ack = 0;
        chk("lb_done", a_done, 1);
        chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
        chk("lb_exc", a_exc, 0);
        chk("lb_req_drop", a_req, 0);
        chk("lb_stall_done", a_stall, 0);
        tick();
        chk("lb_done_clr", a_done, 0);
        chk("lb_rdata_hold", a_rdata, 32'hFFFF_FF80);

        // SH at 0x2002, same-cycle ack
        a_valid = 1; a_op = 7; a_addr = 32'h2002; a_wdata = 32'h0000_ABCD;
        tick();
        a_valid = 0; a_op = 0;
        chk("sh_we", a_we, 1);
        chk("sh_be", a_be, 4'b1100);
        chk("sh_wdata", a_mwdata, 32'hABCD_ABCD);
        chk("sh_addr", a_maddr, 32'h2000);
        a_ack = 1;
        tick();
        a_ack = 0;
        chk("sh_done", a_done, 1);
        chk("sh_rdata", a_rdata, 0);
        chk("sh_exc", a_exc, 0);
        tick();

        // Exceptions: misaligned load, misaligned store, LD on a 32-bit bus
        a_valid = 1; a_op = 1; a_addr = 32'h3001;
        tick();
        a_valid = 0; a_op = 0;
        chk("adel_req", a_req, 0);
        chk("adel_done", a_done, 1);
        chk("adel_exc", a_exc, 1);
        chk("adel_code", a_code, 1);
        tick();
        chk("adel_exc_clr", a_exc, 0);
        a_valid = 1; a_op = 6; a_addr = 32'h3002;
        tick();
        a_valid = 0; a_op = 0;
        chk("ades_code", a_code, 2);
        chk("ades_req", a_req, 0);
        tick();
        a_valid = 1; a_op = 9; a_addr = 32'h3000;
        tick();
        a_valid = 0; a_op = 0;
        chk("ld32_code", a_code, 3);
        chk("ld32_exc", a_exc, 1);
        tick();

        // LHU with no ack: request stays up for exactly TIMEOUT cycles
        a_valid = 1; a_op = 3; a_addr = 32'h4002;
        tick();
        a_valid = 0; a_op = 0;
        n = 0;
        while (a_req === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", n, 4);
        chk("tmo_done", a_done, 1);
        chk("tmo_exc", a_exc, 1);
        chk("tmo_code", a_code, 4);
        tick();

        // Ack on the 4th request cycle wins over the timeout
        a_valid = 1; a_op = 3; a_addr = 32'h4002;
        tick();
        a_valid = 0; a_op = 0;
        tick(); tick(); tick();
        chk("ack4_req", a_req, 1);
        a_ack = 1; a_mrdata = 32'h8001_0000;
        tick();
        a_ack = 0;
        chk("ack4_done", a_done, 1);
        chk("ack4_exc", a_exc, 0);
        chk("ack4_rdata", a_rdata, 32'h0000_8001);
        tick();

        // 64-bit instance: LWU upper lane, LW sign extension, SD
        b_valid = 1; b_op = 10; b_addr = 32'h0000_0104;
        tick();
        b_valid = 0; b_op = 0;
        chk("lwu64_be", b_be, 8'hF0);
        chk("lwu64_addr", b_maddr, 32'h0000_0100);
        b_ack = 1; b_mrdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        b_ack = 0;
        chk("lwu64_done", b_done, 1);
        chk("lwu64_rdata", b_rdata, 64'h0000_0000_DEAD_BEEF);
        tick();
        b_valid = 1; b_op = 1; b_addr = 32'h0000_0100;
        tick();
        b_valid = 0; b_op = 0;
        b_ack = 1; b_mrdata = 64'h0000_0000_8000_0000;
        tick();
        b_ack = 0;
        chk("lw64_rdata", b_rdata, 64'hFFFF_FFFF_8000_0000);
        tick();
        b_valid = 1; b_op = 11; b_addr = 32'h0000_0108; b_wdata = 64'h1122_3344_5566_7788;
        tick();
        b_valid = 0; b_op = 0;
        chk("sd64_be", b_be, 8'hFF);
        chk("sd64_wdata", b_mwdata, 64'h1122_3344_5566_7788);
        chk("sd64_we", b_we, 1);
        b_ack = 1;
        tick();
        b_ack = 0;
        chk("sd64_done", b_done, 1);
        chk("sd64_rdata", b_rdata, 0);
        tick();

        // Flush during REQ: bus cycle completes, result pulse suppressed
        a_valid = 1; a_op = 1; a_addr = 32'h5000;
        tick();
        a_valid = 0; a_op = 0;
        a_flush = 1;
        tick();
        a_flush = 0;
        chk("flush_req_held", a_req, 1);
        a_ack = 1; a_mrdata = 32'h1234_5678;
        tick();
        a_ack = 0;
        chk("flush_done", a_done, 0);
        chk("flush_exc", a_exc, 0);
        chk("flush_req_drop", a_req, 0);
        tick();

        // Flush in IDLE with a valid instruction: not accepted
        a_valid = 1; a_op = 1; a_addr = 32'h5004; a_flush = 1;
        tick();
        a_valid = 0; a_op = 0; a_flush = 0;
        chk("flush_idle_req", a_req, 0);
        chk("flush_idle_done", a_done, 0);
        tick();

        // Reset mid-transaction, late ack ignored, then a normal LW
        a_valid = 1; a_op = 1; a_addr = 32'h6000;
        tick();
        a_valid = 0; a_op = 0;
        chk("rstreq_req", a_req, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rstreq_drop", a_req, 0);
        a_ack = 1; a_mrdata = 32'hBAD0_BAD0;
        tick();
        a_ack = 0;
        chk("late_ack_done", a_done, 0);
        chk("late_ack_rdata", a_rdata, 0);
        a_valid = 1; a_op = 1; a_addr = 32'h6004;
        tick();
        a_valid = 0; a_op = 0;
        chk("post_rst_req", a_req, 1);
        a_ack = 1; a_mrdata = 32'hCAFE_F00D;
        tick();
        a_ack = 0;
        chk("post_rst_done", a_done, 1);
        chk("post_rst_rdata", a_rdata, 32'hCAFE_F00D);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
